// File: rtl/axil_pkg.sv
// Shared constants for the AXI4-Lite register-file backend: response codes,
// write FSM state encoding and byte width.
package axil_pkg;

   localparam int BYTE_W = 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RESP = 1'b1
   } wstate_e;

endpackage

// File: rtl/axil_strb_merge.sv
// Combinational byte-strobe merge: each enabled byte comes from the new word,
// every other byte keeps its old value.
module axil_strb_merge #(
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = 4
) (
   input  logic [DATA_WIDTH-1:0] old_word,
   input  logic [DATA_WIDTH-1:0] new_word,
   input  logic [STRB_WIDTH-1:0] strb,
   output logic [DATA_WIDTH-1:0] merged_word
);
   import axil_pkg::*;

   always_comb begin
      merged_word = old_word;
      for (int i = 0; i < STRB_WIDTH; i++) begin
         if (strb[i]) begin
            merged_word[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
         end
      end
   end

endmodule

// File: rtl/axil_wmem.sv
// Register-file backend for an AXI4-Lite slave: commits each write once with
// byte strobes, returns a B response, and serves a one-cycle-latency read port.
module axil_wmem #(
   parameter int DATA_WIDTH = 32,
   parameter int DATA_DEPTH = 64,
   parameter int ADDR_WIDTH = 5,
   parameter int STRB_WIDTH = 4,
   parameter int RESP_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  WEN,
   input  logic [DATA_WIDTH-1:0] WDATAOUT,
   input  logic [STRB_WIDTH-1:0] WSTRBOUT,
   input  logic [ADDR_WIDTH-1:0] AWADDROUT,
   output logic [RESP_WIDTH-1:0] WRESP,
   output logic                  WRESPREADY,
   input  logic                  REN,
   input  logic [ADDR_WIDTH-1:0] RADDR,
   output logic [DATA_WIDTH-1:0] RDATA,
   output logic                  RERR
);
   import axil_pkg::*;

   localparam int IDX_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;

   logic [1:0]            sync_q, sync_d;
   wstate_e               state_q, state_d;
   logic [RESP_WIDTH-1:0] resp_q, resp_d;
   logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DATA_DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  rerr_q, rerr_d;

   logic                  w_in_range, r_in_range;
   logic [IDX_W-1:0]      widx, ridx;
   logic [DATA_WIDTH-1:0] merged_word;
   logic                  wr_fire;

   function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
      return 32'(a) < DATA_DEPTH;
   endfunction

   // Out-of-range indices are steered to word 0 so the array is never over-indexed.
   always_comb begin
      w_in_range = addr_ok(AWADDROUT);
      r_in_range = addr_ok(RADDR);
      widx       = w_in_range ? IDX_W'(AWADDROUT) : '0;
      ridx       = r_in_range ? IDX_W'(RADDR) : '0;
   end

   // Writes stay blocked until reset release has passed through both sync flops.
   always_comb begin
      sync_d  = {sync_q[0], 1'b1};
      wr_fire = (state_q == S_IDLE) && WEN && sync_q[1];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q  <= '0;
         state_q <= S_IDLE;
         resp_q  <= '0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         resp_q  <= resp_d;
      end
   end

   // RESP ignores every write input except a falling WEN, so a held request commits once.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (wr_fire) state_d = S_RESP;
         S_RESP:  if (!WEN) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      resp_d = resp_q;
      if (wr_fire) begin
         resp_d = w_in_range ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_SLVERR);
      end else if ((state_q == S_RESP) && !WEN) begin
         resp_d = '0;
      end
   end

   always_comb begin
      WRESPREADY = (state_q == S_RESP);
      WRESP      = (state_q == S_RESP) ? resp_q : '0;
   end

   axil_strb_merge #(
      .DATA_WIDTH (DATA_WIDTH),
      .STRB_WIDTH (STRB_WIDTH)
   ) u_strb_merge (
      .old_word    (mem_q[widx]),
      .new_word    (WDATAOUT),
      .strb        (WSTRBOUT),
      .merged_word (merged_word)
   );

   always_comb begin
      for (int i = 0; i < DATA_DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (wr_fire && w_in_range) begin
         mem_d[widx] = merged_word;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DATA_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DATA_DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   // Reads sample mem_q, so a same-edge write to the same word returns the old value.
   always_comb begin
      rdata_d = rdata_q;
      rerr_d  = rerr_q;
      if (REN) begin
         if (r_in_range) begin
            rdata_d = mem_q[ridx];
            rerr_d  = 1'b0;
         end else begin
            rdata_d = '0;
            rerr_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_q <= '0;
         rerr_q  <= 1'b0;
      end else begin
         rdata_q <= rdata_d;
         rerr_q  <= rerr_d;
      end
   end

   assign RDATA = rdata_q;
   assign RERR  = rerr_q;

endmodule

// File: tb/tb_axil_wmem.sv
// Bench for axil_wmem: byte-level reference model compared every cycle, plus
// directed literal checks and a randomized phase.
module tb_axil_wmem;

   localparam int DW    = 32;
   localparam int DEPTH = 20;
   localparam int AW    = 5;
   localparam int SW    = 4;
   localparam int RW    = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          wen = 1'b0;
   logic [DW-1:0] wdata = '0;
   logic [SW-1:0] wstrb = '0;
   logic [AW-1:0] awaddr = '0;
   logic [RW-1:0] wresp;
   logic          wrespready;
   logic          ren = 1'b0;
   logic [AW-1:0] raddr = '0;
   logic [DW-1:0] rdata;
   logic          rerr;

   int tests_run    = 0;
   int tests_failed = 0;
   bit check_en     = 1'b0;

   axil_wmem #(
      .DATA_WIDTH (DW),
      .DATA_DEPTH (DEPTH),
      .ADDR_WIDTH (AW),
      .STRB_WIDTH (SW),
      .RESP_WIDTH (RW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .WEN        (wen),
      .WDATAOUT   (wdata),
      .WSTRBOUT   (wstrb),
      .AWADDROUT  (awaddr),
      .WRESP      (wresp),
      .WRESPREADY (wrespready),
      .REN        (ren),
      .RADDR      (raddr),
      .RDATA      (rdata),
      .RERR       (rerr)
   );

   always #5 clk = ~clk;

   // Reference model: memory as bytes, a busy flag for an outstanding response.
   logic [7:0]    m_mem [32][4];
   logic          m_busy;
   logic [1:0]    m_resp;
   logic [DW-1:0] m_rdata;
   logic          m_rerr;

   function automatic logic [DW-1:0] model_word(input logic [AW-1:0] a);
      return {m_mem[a][3], m_mem[a][2], m_mem[a][1], m_mem[a][0]};
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int w = 0; w < 32; w++) begin
            for (int b = 0; b < 4; b++) begin
               m_mem[w][b] <= 8'h00;
            end
         end
         m_busy  <= 1'b0;
         m_resp  <= 2'b00;
         m_rdata <= '0;
         m_rerr  <= 1'b0;
      end else begin
         if (ren) begin
            if (int'(raddr) < DEPTH) begin
               m_rdata <= model_word(raddr);
               m_rerr  <= 1'b0;
            end else begin
               m_rdata <= '0;
               m_rerr  <= 1'b1;
            end
         end
         if (!m_busy) begin
            if (wen) begin
               if (int'(awaddr) < DEPTH) begin
                  for (int b = 0; b < 4; b++) begin
                     if (wstrb[b]) m_mem[awaddr][b] <= wdata[8*b +: 8];
                  end
                  m_resp <= 2'b00;
               end else begin
                  m_resp <= 2'b10;
               end
               m_busy <= 1'b1;
            end
         end else if (!wen) begin
            m_busy <= 1'b0;
            m_resp <= 2'b00;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         checkOutput("cmp_wrespready", 64'(wrespready), 64'(m_busy));
         checkOutput("cmp_wresp", 64'(wresp), m_busy ? 64'(m_resp) : 64'd0);
         checkOutput("cmp_rdata", 64'(rdata), 64'(m_rdata));
         checkOutput("cmp_rerr", 64'(rerr), 64'(m_rerr));
      end
   end

   // Drives one cycle of inputs, then returns 1 time unit after the sampling edge.
   task automatic applyStimulus(input logic w, input logic [AW-1:0] aa,
                                input logic [DW-1:0] d, input logic [SW-1:0] s,
                                input logic r, input logic [AW-1:0] ra);
      wen    = w;
      awaddr = aa;
      wdata  = d;
      wstrb  = s;
      ren    = r;
      raddr  = ra;
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
   endtask

   initial begin
      reset = 1'b1;
      #2 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_en = 1'b1;
      checkOutput("reset_wrespready", 64'(wrespready), 64'd0);
      checkOutput("reset_wresp", 64'(wresp), 64'd0);
      checkOutput("reset_rdata", 64'(rdata), 64'd0);
      checkOutput("reset_rerr", 64'(rerr), 64'd0);
      reset = 1'b1;
      idleCycles(4);

      applyStimulus(1'b1, 5'd3, 32'hDEADBEEF, 4'hF, 1'b0, '0);
      checkOutput("full_wrespready", 64'(wrespready), 64'd1);
      checkOutput("full_wresp", 64'(wresp), 64'd0);
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'd3);
      checkOutput("full_ready_drop", 64'(wrespready), 64'd0);
      checkOutput("full_rdata", 64'(rdata), 64'hDEADBEEF);

      applyStimulus(1'b1, 5'd5, 32'h11223344, 4'hF, 1'b0, '0);
      applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
      applyStimulus(1'b1, 5'd5, 32'hAABBCCDD, 4'b0101, 1'b0, '0);
      checkOutput("partial_wresp", 64'(wresp), 64'd0);
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'd5);
      checkOutput("partial_rdata", 64'(rdata), 64'h11BB33DD);

      applyStimulus(1'b1, 5'd9, 32'hCAFE0001, 4'hF, 1'b0, '0);
      checkOutput("held_ready_1", 64'(wrespready), 64'd1);
      applyStimulus(1'b1, 5'd9, 32'hCAFE0001, 4'hF, 1'b0, '0);
      checkOutput("held_ready_2", 64'(wrespready), 64'd1);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 5'd10, 32'h0BAD0BAD, 4'hF, 1'b0, '0);
         checkOutput("held_ready_n", 64'(wrespready), 64'd1);
      end
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'd9);
      checkOutput("held_ready_low", 64'(wrespready), 64'd0);
      checkOutput("held_rdata_once", 64'(rdata), 64'hCAFE0001);
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'd10);
      checkOutput("held_no_second", 64'(rdata), 64'd0);

      applyStimulus(1'b1, 5'd25, 32'h12345678, 4'hF, 1'b0, '0);
      checkOutput("oor_wresp", 64'(wresp), 64'h2);
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'd25);
      checkOutput("oor_rerr", 64'(rerr), 64'd1);
      checkOutput("oor_rdata", 64'(rdata), 64'd0);
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'd5);
      checkOutput("oor_rerr_clear", 64'(rerr), 64'd0);
      checkOutput("oor_no_change", 64'(rdata), 64'h11BB33DD);

      applyStimulus(1'b1, 5'd7, 32'h5A5A5A5A, 4'hF, 1'b1, 5'd7);
      checkOutput("coll_old", 64'(rdata), 64'd0);
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'd7);
      checkOutput("coll_new", 64'(rdata), 64'h5A5A5A5A);
      applyStimulus(1'b0, '0, '0, '0, 1'b0, 5'd3);
      checkOutput("ren_low_hold", 64'(rdata), 64'h5A5A5A5A);

      applyStimulus(1'b1, 5'd0, 32'h0, 4'h0, 1'b0, '0);
      checkOutput("strb0_wresp", 64'(wresp), 64'd0);
      applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);

      for (int i = 0; i < 600; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                       4'($urandom), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      end
      idleCycles(2);

      applyStimulus(1'b1, 5'd2, 32'hFFFFFFFF, 4'hF, 1'b0, '0);
      checkOutput("arst_pre_ready", 64'(wrespready), 64'd1);
      #2 reset = 1'b0;
      #1;
      checkOutput("arst_ready_async", 64'(wrespready), 64'd0);
      checkOutput("arst_wresp_async", 64'(wresp), 64'd0);
      wen = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      idleCycles(4);
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'(i));
         checkOutput("arst_cleared", 64'(rdata), 64'd0);
      end
      idleCycles(2);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/axil_wmem.md
Name: axil_wmem

Overview:
Register-file backend that sits directly downstream of the AXI4-Lite slave write path.
- Consumes the write path's memory-side outputs (write enable, data, strobe, word address).
- Commits each write exactly once with per-byte strobes.
- Returns a response code plus a response-valid indication to the write path's B channel.
- Provides a one-cycle-latency read port for the slave read path.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8
DATA_DEPTH, 64, number of implemented words; a word index >= DATA_DEPTH is out of range
ADDR_WIDTH, 5, word-index width of the write and read addresses
STRB_WIDTH, 4, byte-strobe width; equals DATA_WIDTH/8
RESP_WIDTH, 2, response code width

Ports:
clk  in  1  single clock; all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
WEN  in  1  write request; level, held high by the write path until the response is consumed
WDATAOUT  in  DATA_WIDTH  write data
WSTRBOUT  in  STRB_WIDTH  byte strobes; bit i enables byte i
AWADDROUT  in  ADDR_WIDTH  write word index
WRESP  out  RESP_WIDTH  write response code
WRESPREADY  out  1  response valid to the write path
REN  in  1  read request, single-cycle
RADDR  in  ADDR_WIDTH  read word index
RDATA  out  DATA_WIDTH  read data, registered
RERR  out  1  read address out of range, registered with RDATA

Behaviour:
- Reset (reset=0, async): state=IDLE, WRESPREADY=0, WRESP=2'b00, RDATA=0, RERR=0, all memory words = 0. Release is synchronised to clk internally with a 2-flop synchroniser; the first write is accepted no earlier than the 2nd edge after deassertion.
- Write FSM states: IDLE, RESP.
- IDLE, WEN=1 at edge N:
  - Write: if AWADDROUT < DATA_DEPTH, byte i of mem[AWADDROUT] <= WDATAOUT byte i for every WSTRBOUT[i]=1; other bytes unchanged.
  - Response: WRESP <= OKAY (2'b00) in range; SLVERR (2'b10) out of range with no memory change. WSTRBOUT=0 gives OKAY with no change.
  - WRESPREADY <= 1, state <= RESP. Response is visible from cycle N+1 (1-cycle latency).
- RESP:
  - WRESP and WRESPREADY held stable; WEN and all write inputs ignored, so a held WEN never causes a second commit.
  - WEN=0 at an edge -> WRESPREADY <= 0, WRESP <= 0, state <= IDLE.
  - Minimum WRESPREADY pulse is 1 cycle. Back-to-back writes need at least one WEN-low cycle between them.
- IDLE with WEN=0: no change.
- Read port, independent of the write FSM:
  - REN=1 at edge N -> RDATA = mem[RADDR], RERR=0 from N+1 if in range; otherwise RDATA=0, RERR=1.
  - REN=0 -> RDATA and RERR hold their last values.
- Read/write collision (same word, same edge): read-first; RDATA returns the pre-write value, and the new value is visible to a read one cycle later.
- Reset mid-transaction (in RESP): WRESPREADY drops immediately (async). Memory is cleared and the pending response is lost; the write path is reset by the same signal.
- Address compare is unsigned on ADDR_WIDTH bits. If DATA_DEPTH >= 2^ADDR_WIDTH, out-of-range never occurs.

Decomposition:
- Shared package axil_pkg:
  - RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - write FSM state encodings S_IDLE, S_RESP
  - constant BYTE_W=8
- One sub-module, axil_strb_merge: combinational merge of old word, new word and strobe into the next word. Instantiated once on the write path.

Test Plan:
- Reset then full write: WEN=1, AWADDROUT=3, WDATAOUT=32'hDEADBEEF, WSTRBOUT=4'hF -> WRESPREADY=1, WRESP=00 next cycle; REN at word 3 -> RDATA=32'hDEADBEEF.
- Partial strobe: mem[5]=32'h11223344, write 32'hAABBCCDD with WSTRBOUT=4'b0101 -> mem[5]=32'h11BB33DD, WRESP=00.
- Held WEN: WEN high 6 cycles with WDATAOUT changing on cycle 3 -> exactly one commit of the cycle-1 data; WRESPREADY high cycles 2-6, low the cycle after WEN drops.
- Out of range with DATA_DEPTH=20: write to index 25 -> WRESP=2'b10, no word changes; REN at RADDR=25 -> RERR=1, RDATA=0.
- Collision: mem[7]=32'h0, write 32'h5A5A5A5A to 7 and REN at RADDR=7 on the same edge -> RDATA=0; a read one cycle later -> 32'h5A5A5A5A.
- Async reset while in RESP -> WRESPREADY=0 without a clock edge; all words read 0 after release.
